// File: rtl/floo_axis_vc_link_scheduler.sv
// Credit-based virtual-channel scheduler sharing one AXIS link between NumChan NoC channels.
// Define FLOO_VC_SCHED_RSP_PRIO_EN for fixed highest-index-first data arbitration instead of round-robin.
module floo_axis_vc_link_scheduler #(
   parameter int NumChan    = 2,
   parameter int NumCredits = 8,
   parameter int CntW       = $clog2(NumCredits + 1),
   parameter int SelW       = $clog2(NumChan)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NumChan-1:0]      chan_valid_i,
   output logic [NumChan-1:0]      chan_ready_o,
   output logic [SelW-1:0]         sel_o,
   output logic                    link_valid_o,
   input  logic                    link_ready_i,
   output logic                    data_valid_o,
   output logic [SelW-1:0]         ret_chan_o,
   output logic [CntW-1:0]         ret_cnt_o,
   input  logic                    credit_valid_i,
   input  logic [SelW-1:0]         credit_chan_i,
   input  logic [CntW-1:0]         credit_cnt_i,
   input  logic [NumChan-1:0]      rx_consume_i,
   output logic [NumChan*CntW-1:0] credits_o
);

   // state | meaning
   // IDLE  | arbitrate every cycle, outputs follow inputs combinationally
   // HOLD  | beat offered but not taken; outputs frozen until link_ready_i
   typedef enum logic {IDLE, HOLD} state_e;

   state_e          state;
   logic [CntW-1:0] credit [NumChan];
   logic [CntW-1:0] pend   [NumChan];
   logic [SelW-1:0] ret_ptr;
`ifndef FLOO_VC_SCHED_RSP_PRIO_EN
   logic [SelW-1:0] data_ptr;
`endif

   logic [SelW-1:0] hold_sel;
   logic            hold_dv;
   logic [SelW-1:0] hold_ret_chan;
   logic [CntW-1:0] hold_ret_cnt;

   logic [NumChan-1:0] elig;
   logic [NumChan-1:0] has_pend;
   logic [SelW-1:0]    data_gnt;
   logic [SelW-1:0]    ret_gnt;
   logic               ret_found;
   logic               commit;

   logic [CntW:0]   credit_sum [NumChan];
   logic [CntW:0]   pend_sum   [NumChan];
   logic [CntW-1:0] credit_nxt [NumChan];
   logic [CntW-1:0] pend_nxt   [NumChan];

   function automatic logic [SelW-1:0] next_idx(input logic [SelW-1:0] idx);
      return (int'(idx) == NumChan - 1) ? '0 : idx + 1'b1;
   endfunction

   always_comb begin
      elig     = '0;
      has_pend = '0;
      for (int c = 0; c < NumChan; c++) begin
         elig[c]     = chan_valid_i[c] && (credit[c] != '0);
         has_pend[c] = (pend[c] != '0);
      end
   end

`ifdef FLOO_VC_SCHED_RSP_PRIO_EN
   // Highest index wins so responses drain ahead of requests.
   always_comb begin
      logic [SelW-1:0] cand;
      data_gnt = '0;
      cand     = '0;
      for (int i = 0; i < NumChan; i++) begin
         cand = SelW'(i);
         if (elig[cand]) data_gnt = cand;
      end
   end
`else
   always_comb begin
      logic [SelW-1:0] cand;
      logic            found;
      data_gnt = '0;
      cand     = '0;
      found    = 1'b0;
      for (int i = 0; i < NumChan; i++) begin
         cand = SelW'((int'(data_ptr) + i) % NumChan);
         if (!found && elig[cand]) begin
            found    = 1'b1;
            data_gnt = cand;
         end
      end
   end
`endif

   always_comb begin
      logic [SelW-1:0] cand;
      ret_gnt   = '0;
      ret_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < NumChan; i++) begin
         cand = SelW'((int'(ret_ptr) + i) % NumChan);
         if (!ret_found && has_pend[cand]) begin
            ret_found = 1'b1;
            ret_gnt   = cand;
         end
      end
   end

   // Outputs are forced quiet while reset is asserted so no beat leaks out mid-reset.
   always_comb begin
      if (state == HOLD) begin
         sel_o        = hold_sel;
         data_valid_o = hold_dv;
         ret_chan_o   = hold_ret_chan;
         ret_cnt_o    = hold_ret_cnt;
         link_valid_o = 1'b1;
      end else begin
         sel_o        = data_gnt;
         data_valid_o = |elig;
         ret_chan_o   = ret_gnt;
         ret_cnt_o    = ret_found ? pend[ret_gnt] : '0;
         link_valid_o = (|elig) || (|has_pend);
      end
      if (rst_i) begin
         data_valid_o = 1'b0;
         ret_cnt_o    = '0;
         link_valid_o = 1'b0;
      end
   end

   assign commit = link_valid_o && link_ready_i;

   always_comb begin
      chan_ready_o = '0;
      if (commit && data_valid_o) chan_ready_o[sel_o] = 1'b1;
   end

   // Net per-cycle update; a take and a return on the same channel cancel out.
   always_comb begin
      for (int c = 0; c < NumChan; c++) begin
         credit_sum[c] = {1'b0, credit[c]};
         if (credit_valid_i && (credit_chan_i == SelW'(c)))
            credit_sum[c] = credit_sum[c] + {1'b0, credit_cnt_i};
         if (chan_ready_o[c])
            credit_sum[c] = credit_sum[c] - (CntW+1)'(1);
         credit_nxt[c] = (credit_sum[c] > (CntW+1)'(NumCredits)) ? CntW'(NumCredits)
                                                                 : credit_sum[c][CntW-1:0];

         pend_sum[c] = {1'b0, pend[c]} + (CntW+1)'(rx_consume_i[c]);
         if (commit && (ret_cnt_o != '0) && (ret_chan_o == SelW'(c)))
            pend_sum[c] = pend_sum[c] - {1'b0, ret_cnt_o};
         pend_nxt[c] = (pend_sum[c] > (CntW+1)'(NumCredits)) ? CntW'(NumCredits)
                                                             : pend_sum[c][CntW-1:0];
      end
   end

   always_comb begin
      credits_o = '0;
      for (int c = 0; c < NumChan; c++) credits_o[c*CntW +: CntW] = credit[c];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         ret_ptr       <= '0;
`ifndef FLOO_VC_SCHED_RSP_PRIO_EN
         data_ptr      <= '0;
`endif
         hold_sel      <= '0;
         hold_dv       <= 1'b0;
         hold_ret_chan <= '0;
         hold_ret_cnt  <= '0;
         for (int c = 0; c < NumChan; c++) begin
            credit[c] <= CntW'(NumCredits);
            pend[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < NumChan; c++) begin
            credit[c] <= credit_nxt[c];
            pend[c]   <= pend_nxt[c];
         end
`ifndef FLOO_VC_SCHED_RSP_PRIO_EN
         if (commit && data_valid_o) data_ptr <= next_idx(sel_o);
`endif
         if (commit && (ret_cnt_o != '0)) ret_ptr <= next_idx(ret_chan_o);
         case (state)
            IDLE: begin
               if (link_valid_o && !link_ready_i) begin
                  hold_sel      <= sel_o;
                  hold_dv       <= data_valid_o;
                  hold_ret_chan <= ret_chan_o;
                  hold_ret_cnt  <= ret_cnt_o;
                  state         <= HOLD;
               end
            end
            HOLD: begin
               if (link_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int c = 0; c < NumChan; c++) begin
            if (credit_sum[c] > (CntW+1)'(NumCredits))
               $error("credit counter overflow on channel %0d", c);
            if (pend_sum[c] > (CntW+1)'(NumCredits))
               $error("pending return counter overflow on channel %0d", c);
         end
      end
   end
`endif

endmodule

// File: tb/tb_floo_axis_vc_link_scheduler.sv
// Self-checking bench for floo_axis_vc_link_scheduler: vector table, corner sequences, random vs model.
module tb_floo_axis_vc_link_scheduler;
   localparam int NC  = 2;
   localparam int NCR = 8;
   localparam int CW  = 4;
   localparam int SW  = 1;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [NC-1:0] chan_valid_i;
   logic [NC-1:0] chan_ready_o;
   logic [SW-1:0] sel_o;
   logic          link_valid_o;
   logic          link_ready_i;
   logic          data_valid_o;
   logic [SW-1:0] ret_chan_o;
   logic [CW-1:0] ret_cnt_o;
   logic          credit_valid_i;
   logic [SW-1:0] credit_chan_i;
   logic [CW-1:0] credit_cnt_i;
   logic [NC-1:0] rx_consume_i;
   logic [NC*CW-1:0] credits_o;

   always #5 clk_i = ~clk_i;

   floo_axis_vc_link_scheduler #(.NumChan(NC), .NumCredits(NCR)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .chan_valid_i(chan_valid_i), .chan_ready_o(chan_ready_o), .sel_o(sel_o),
      .link_valid_o(link_valid_o), .link_ready_i(link_ready_i), .data_valid_o(data_valid_o),
      .ret_chan_o(ret_chan_o), .ret_cnt_o(ret_cnt_o),
      .credit_valid_i(credit_valid_i), .credit_chan_i(credit_chan_i), .credit_cnt_i(credit_cnt_i),
      .rx_consume_i(rx_consume_i), .credits_o(credits_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [1:0] cv, input logic rdy, input logic crv,
                         input logic crc, input logic [3:0] crn, input logic [1:0] cons);
      chan_valid_i   = cv;
      link_ready_i   = rdy;
      credit_valid_i = crv;
      credit_chan_i  = crc;
      credit_cnt_i   = crn;
      rx_consume_i   = cons;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   typedef struct {
      logic [1:0] cv;  logic rdy; logic crv; logic crc; logic [3:0] crn; logic [1:0] cons;
      logic [1:0] e_rdy; logic e_sel; logic e_dv; logic e_lv; logic e_rc; logic [3:0] e_rn;
      logic [7:0] e_cred;
   } vec_t;

   vec_t tbl[10];

   // Behavioural model state
   int  m_cred[NC];
   int  m_pend[NC];
   int  m_dnext, m_rnext;
   bit  m_hold;
   int  h_sel, h_dv, h_rc, h_rn;

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         m_cred[c] = NCR;
         m_pend[c] = 0;
      end
      m_dnext = 0; m_rnext = 0; m_hold = 0;
      h_sel = 0; h_dv = 0; h_rc = 0; h_rn = 0;
   endtask

   task automatic model_step();
      int sel, dv, rc, rn, lv, c, exp_rdy;
      sel = 0; dv = 0; rc = 0; rn = 0;
      if (m_hold) begin
         sel = h_sel; dv = h_dv; rc = h_rc; rn = h_rn; lv = 1;
      end else begin
         for (int k = 0; k < NC; k++) begin
            c = (m_dnext + k) % NC;
            if (dv == 0 && chan_valid_i[c] && m_cred[c] > 0) begin dv = 1; sel = c; end
         end
         for (int k = 0; k < NC; k++) begin
            c = (m_rnext + k) % NC;
            if (rn == 0 && m_pend[c] > 0) begin rn = m_pend[c]; rc = c; end
         end
         lv = (dv != 0 || m_pend[0] > 0 || m_pend[1] > 0) ? 1 : 0;
      end
      exp_rdy = (lv != 0 && link_ready_i && dv != 0) ? (1 << sel) : 0;
      chk("rnd_link_valid", int'(link_valid_o), lv);
      chk("rnd_data_valid", int'(data_valid_o), dv);
      chk("rnd_chan_ready", int'(chan_ready_o), exp_rdy);
      chk("rnd_ret_cnt", int'(ret_cnt_o), rn);
      chk("rnd_credits", int'(credits_o), m_cred[0] + 16 * m_cred[1]);
      if (dv != 0) chk("rnd_sel", int'(sel_o), sel);
      if (rn != 0) chk("rnd_ret_chan", int'(ret_chan_o), rc);
      if (lv != 0 && link_ready_i) begin
         if (dv != 0) begin m_cred[sel]--; m_dnext = (sel + 1) % NC; end
         if (rn != 0) begin m_pend[rc] -= rn; m_rnext = (rc + 1) % NC; end
         m_hold = 0;
      end else if (lv != 0 && !m_hold) begin
         m_hold = 1; h_sel = sel; h_dv = dv; h_rc = rc; h_rn = rn;
      end
      if (credit_valid_i) m_cred[credit_chan_i] += int'(credit_cnt_i);
      for (int k = 0; k < NC; k++) m_pend[k] += int'(rx_consume_i[k]);
   endtask

   initial begin
      int n0;
      int cc;
      logic [1:0] cv;
      logic [1:0] cons;
      tbl[0] = '{2'b00,1'b1,1'b0,1'b0,4'd0,2'b00, 2'b00,1'b0,1'b0,1'b0,1'b0,4'd0,8'h88};
      tbl[1] = '{2'b11,1'b1,1'b0,1'b0,4'd0,2'b00, 2'b01,1'b0,1'b1,1'b1,1'b0,4'd0,8'h88};
      tbl[2] = '{2'b11,1'b1,1'b0,1'b0,4'd0,2'b00, 2'b10,1'b1,1'b1,1'b1,1'b0,4'd0,8'h87};
      tbl[3] = '{2'b01,1'b1,1'b0,1'b0,4'd0,2'b10, 2'b01,1'b0,1'b1,1'b1,1'b0,4'd0,8'h77};
      tbl[4] = '{2'b00,1'b1,1'b0,1'b0,4'd0,2'b00, 2'b00,1'b0,1'b0,1'b1,1'b1,4'd1,8'h76};
      tbl[5] = '{2'b10,1'b0,1'b0,1'b0,4'd0,2'b01, 2'b00,1'b1,1'b1,1'b1,1'b0,4'd0,8'h76};
      tbl[6] = '{2'b10,1'b0,1'b0,1'b0,4'd0,2'b00, 2'b00,1'b1,1'b1,1'b1,1'b0,4'd0,8'h76};
      tbl[7] = '{2'b10,1'b1,1'b1,1'b0,4'd2,2'b00, 2'b10,1'b1,1'b1,1'b1,1'b0,4'd0,8'h76};
      tbl[8] = '{2'b00,1'b1,1'b0,1'b0,4'd0,2'b00, 2'b00,1'b0,1'b0,1'b1,1'b0,4'd1,8'h68};
      tbl[9] = '{2'b00,1'b1,1'b0,1'b0,4'd0,2'b00, 2'b00,1'b0,1'b0,1'b0,1'b0,4'd0,8'h68};

      do_reset();
      @(negedge clk_i);
      chk("reset_link_valid", int'(link_valid_o), 0);
      chk("reset_chan_ready", int'(chan_ready_o), 0);
      chk("reset_credits", int'(credits_o), 8'h88);

      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].cv, tbl[i].rdy, tbl[i].crv, tbl[i].crc, tbl[i].crn, tbl[i].cons);
         @(negedge clk_i);
         chk($sformatf("vec%0d_chan_ready", i), int'(chan_ready_o), int'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_data_valid", i), int'(data_valid_o), int'(tbl[i].e_dv));
         chk($sformatf("vec%0d_link_valid", i), int'(link_valid_o), int'(tbl[i].e_lv));
         chk($sformatf("vec%0d_ret_cnt", i), int'(ret_cnt_o), int'(tbl[i].e_rn));
         chk($sformatf("vec%0d_credits", i), int'(credits_o), int'(tbl[i].e_cred));
         if (tbl[i].e_dv) chk($sformatf("vec%0d_sel", i), int'(sel_o), int'(tbl[i].e_sel));
         if (tbl[i].e_rn != 0) chk($sformatf("vec%0d_ret_chan", i), int'(ret_chan_o), int'(tbl[i].e_rc));
         tick();
      end

      // Chan0 alone drains its 8 credits, then blocks; chan1 proceeds; a 3-credit return gives 3 beats.
      do_reset();
      set_in(2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         chk($sformatf("drain_beat%0d", i), int'(chan_ready_o), 1);
         tick();
      end
      @(negedge clk_i);
      chk("drain_blocked_ready", int'(chan_ready_o), 0);
      chk("drain_blocked_link_valid", int'(link_valid_o), 0);
      chk("drain_credit0", int'(credits_o[3:0]), 0);
      tick();
      set_in(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("nohol_chan1_ready", int'(chan_ready_o), 2);
         tick();
      end
      set_in(2'b11, 1'b1, 1'b1, 1'b0, 4'd3, 2'b00);
      @(negedge clk_i);
      chk("nohol_ret_cycle_ready", int'(chan_ready_o), 2);
      tick();
      set_in(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      n0 = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_i);
         if (chan_ready_o[0]) n0++;
         tick();
      end
      chk("resume_chan0_beats", n0, 3);
      @(negedge clk_i);
      chk("resume_all_credits_used", int'(credits_o), 0);
      tick();

      // Round-robin alternation with both channels valid.
      do_reset();
      set_in(2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk($sformatf("rr_sel%0d", i), int'(sel_o), i % 2);
         chk($sformatf("rr_ready%0d", i), int'(chan_ready_o), 1 << (i % 2));
         tick();
      end

      // Credit-only beat held then committed with the captured count.
      do_reset();
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 2'b10);
      @(negedge clk_i);
      chk("crd_only_idle", int'(link_valid_o), 0);
      tick();
      @(negedge clk_i);
      chk("crd_only_valid", int'(link_valid_o), 1);
      chk("crd_only_dv", int'(data_valid_o), 0);
      chk("crd_only_ret_chan", int'(ret_chan_o), 1);
      chk("crd_only_ret_cnt", int'(ret_cnt_o), 1);
      tick();
      @(negedge clk_i);
      chk("crd_only_held_cnt", int'(ret_cnt_o), 1);
      tick();
      set_in(2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      @(negedge clk_i);
      chk("crd_only_commit_valid", int'(link_valid_o), 1);
      chk("crd_only_commit_dv", int'(data_valid_o), 0);
      chk("crd_only_commit_ready", int'(chan_ready_o), 0);
      chk("crd_only_commit_cnt", int'(ret_cnt_o), 1);
      tick();
      @(negedge clk_i);
      chk("crd_only_rest_chan", int'(ret_chan_o), 1);
      chk("crd_only_rest_cnt", int'(ret_cnt_o), 2);
      tick();
      @(negedge clk_i);
      chk("crd_only_drained", int'(link_valid_o), 0);
      tick();

      // Five-cycle backpressure with new traffic: outputs stable, single commit.
      do_reset();
      set_in(2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 2'b01);
      tick();
      set_in(2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 2'b10);
      @(negedge clk_i);
      chk("stall_first_sel", int'(sel_o), 0);
      chk("stall_first_ret_cnt", int'(ret_cnt_o), 1);
      tick();
      set_in(2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 2'b10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("stall_sel", int'(sel_o), 0);
         chk("stall_dv", int'(data_valid_o), 1);
         chk("stall_ret_chan", int'(ret_chan_o), 0);
         chk("stall_ret_cnt", int'(ret_cnt_o), 1);
         chk("stall_ready", int'(chan_ready_o), 0);
         tick();
      end
      set_in(2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      @(negedge clk_i);
      chk("stall_commit_ready", int'(chan_ready_o), 1);
      chk("stall_commit_ret_cnt", int'(ret_cnt_o), 1);
      tick();
      set_in(2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      @(negedge clk_i);
      chk("stall_after_credit0", int'(credits_o[3:0]), 7);
      chk("stall_after_ret_chan", int'(ret_chan_o), 1);
      chk("stall_after_ret_cnt", int'(ret_cnt_o), 6);
      tick();

      // Same-cycle take and return leaves the counter unchanged.
      do_reset();
      set_in(2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      repeat (4) tick();
      set_in(2'b01, 1'b1, 1'b1, 1'b0, 4'd1, 2'b00);
      @(negedge clk_i);
      chk("net_take_ready", int'(chan_ready_o), 1);
      chk("net_before", int'(credits_o[3:0]), 4);
      tick();
      set_in(2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      @(negedge clk_i);
      chk("net_after", int'(credits_o[3:0]), 4);
      tick();

      // Reset while holding aborts the beat.
      do_reset();
      set_in(2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      @(negedge clk_i);
      chk("rst_hold_valid", int'(link_valid_o), 1);
      tick();
      @(negedge clk_i);
      #1;
      rst_i = 1'b1;
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      tick();
      @(negedge clk_i);
      chk("rst_hold_in_reset_valid", int'(link_valid_o), 0);
      chk("rst_hold_credits", int'(credits_o), 8'h88);
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_hold_released_valid", int'(link_valid_o), 0);
      chk("rst_hold_released_credits", int'(credits_o), 8'h88);
      tick();

      // Randomized traffic against the model.
      do_reset();
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         cv = 2'($urandom_range(0, 3));
         if (m_hold && h_dv != 0) cv[h_sel] = 1'b1;
         cons = 2'b00;
         for (int c = 0; c < NC; c++)
            if (m_pend[c] < NCR && $urandom_range(0, 2) == 0) cons[c] = 1'b1;
         cc = $urandom_range(0, 1);
         set_in(cv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), cc[0],
                4'($urandom_range(0, NCR - m_cred[cc])), cons);
         @(negedge clk_i);
         model_step();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
